// File: rtl/tt_prakh_pkg.sv
// Shared constants for the byte FIFO tile: the default depth, uio pin
// assignments and the output-enable mask.
package tt_prakh_pkg;

  localparam int FIFO_DEPTH = 8;

  localparam int WR_STB    = 0;
  localparam int RD_STB    = 1;
  localparam int FULL_BIT  = 2;
  localparam int EMPTY_BIT = 3;
  localparam int LEVEL_LSB = 4;

  localparam logic [7:0] UIO_OE_MASK = 8'hFC;

endpackage

// File: rtl/tt_prakh_strobe_sync.sv
// Brings an asynchronous host strobe into the clk domain and emits a single
// registered one-cycle pulse for each synchronized rising edge.
module tt_prakh_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_event;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Everything resets to 0, so a pin held high across reset release is seen
  // as a fresh rising edge only once it has crossed the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_hist  <= 1'b0;
      r_event <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist  <= w_sync_out;
      r_event <= w_sync_out & ~r_hist;
    end
  end

  assign event_o = r_event;

endmodule

// File: rtl/tt_um_prakh_byte_fifo.sv
// Tiny Tapeout inbound byte FIFO: host pushes bytes with a write strobe and
// pops with a read strobe; head byte and full/empty/level are always visible.
module tt_um_prakh_byte_fifo
  import tt_prakh_pkg::*;
#(
  parameter int DEPTH       = FIFO_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = 4;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic          w_wr_ev;
  logic          w_rd_ev;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

  logic [7:0]    r_data_p [SYNC_STAGES];
  logic [7:0]    r_mem    [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  tt_prakh_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (uio_in[WR_STB]),
    .event_o  (w_wr_ev)
  );

  tt_prakh_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (uio_in[RD_STB]),
    .event_o  (w_rd_ev)
  );

  // Data delay line matching the strobe chain; the host holds ui_in stable
  // long enough that no reset or metastability handling is needed here.
  always_ff @(posedge clk) begin
    r_data_p[0] <= ui_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      r_data_p[i] <= r_data_p[i-1];
    end
  end

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_pop   = w_rd_ev & ~w_empty;
  assign w_push  = w_wr_ev & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_data_p[SYNC_STAGES-1];
  end

  // Stale storage is masked while empty, so uo_out is 0 straight out of reset.
  assign uo_out = w_empty ? 8'h00 : r_mem[r_rptr];

  always_comb begin
    uio_out                       = 8'h00;
    uio_out[FULL_BIT]             = w_full;
    uio_out[EMPTY_BIT]            = w_empty;
    uio_out[LEVEL_LSB +: LW]      = r_level;
  end

  assign uio_oe = UIO_OE_MASK;

  assign w_unused = &{1'b0, ena, uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_prakh_byte_fifo.sv
// Self-checking bench for the byte FIFO tile: directed scenarios plus random
// strobe traffic compared against a queue-based reference model.
module tb_tt_um_prakh_byte_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_errors;
  logic [7:0] q[$];

  tt_um_prakh_byte_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived purely from the model queue.
  task automatic check_state(input string tag);
    logic [7:0] exp_head;
    exp_head = (q.size() == 0) ? 8'h00 : q[0];
    chk({tag, ".uo_out"}, 32'(uo_out),      32'(exp_head));
    chk({tag, ".level"},  32'(uio_out[7:4]), 32'(q.size()));
    chk({tag, ".full"},   32'(uio_out[2]),  32'(q.size() == DEPTH));
    chk({tag, ".empty"},  32'(uio_out[3]),  32'(q.size() == 0));
    chk({tag, ".low"},    32'(uio_out[1:0]), 32'(0));
    chk({tag, ".oe"},     32'(uio_oe),      32'(8'hFC));
  endtask

  task automatic model_apply(input logic wr, input logic rd, input logic [7:0] d);
    int  sz;
    logic do_pop, do_push;
    sz      = q.size();
    do_pop  = rd && (sz != 0);
    do_push = wr && ((sz != DEPTH) || do_pop);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
  endtask

  // Setup data, raise strobes for 4 clocks, drop for 4 clocks, then update model.
  task automatic strobe(input logic wr, input logic rd, input logic [7:0] d);
    @(negedge clk);
    ui_in = d;
    repeat (4) @(negedge clk);
    uio_in[0] = wr;
    uio_in[1] = rd;
    repeat (4) @(negedge clk);
    uio_in[1:0] = 2'b00;
    repeat (4) @(negedge clk);
    model_apply(wr, rd, d);
  endtask

  task automatic do_reset(input logic [1:0] stb);
    @(negedge clk);
    uio_in[1:0] = stb;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ena      = 1'b1;
    rst_n    = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;

    // Reset with both strobes high: one push, read ignored as FIFO was empty.
    ui_in = 8'h5A;
    do_reset(2'b11);
    #1 check_state("rst");
    @(posedge clk); #1 check_state("rst_edge1");
    repeat (6) @(posedge clk);
    #1;
    model_apply(1'b1, 1'b1, 8'h5A);
    check_state("rst_held");
    chk("rst_held.level1", 32'(uio_out[7:4]), 32'd1);
    @(negedge clk);
    uio_in[1:0] = 2'b00;
    repeat (4) @(negedge clk);

    // Latency: head shows A5 exactly SYNC+1 clocks after the first sampling edge.
    do_reset(2'b00);
    @(negedge clk);
    ui_in = 8'hA5;
    repeat (4) @(negedge clk);
    uio_in[0] = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1 chk("lat.before", 32'(uo_out), 32'h00);
    @(posedge clk);
    #1 chk("lat.at", 32'(uo_out), 32'hA5);
    @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    model_apply(1'b1, 1'b0, 8'hA5);
    strobe(1'b1, 1'b0, 8'h3C);
    check_state("wr2");

    // Pop twice then once more on empty.
    strobe(1'b0, 1'b1, 8'h00); check_state("pop1");
    strobe(1'b0, 1'b1, 8'h00); check_state("pop2");
    strobe(1'b0, 1'b1, 8'h00); check_state("pop_empty");

    // Overfill with 9 bytes; the ninth is dropped.
    for (int i = 1; i <= 9; i++) begin
      strobe(1'b1, 1'b0, 8'(i));
    end
    check_state("fill");
    chk("fill.full", 32'(uio_out[2]), 32'd1);

    // Simultaneous wr/rd while full.
    strobe(1'b1, 1'b1, 8'hEE);
    check_state("simul_full");
    for (int i = 0; i < 8; i++) begin
      strobe(1'b0, 1'b1, 8'h00);
      check_state("drain");
    end

    // Asynchronous reset mid-stream at level 5.
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 8'(8'h40 + i));
    check_state("pre_rst5");
    @(posedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    #1 check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    strobe(1'b1, 1'b0, 8'h77);
    check_state("post_rst");

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic wr, rd;
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!wr && !rd) wr = 1'b1;
      strobe(wr, rd, 8'($urandom));
      check_state("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
